data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the load/store control the decode stage emits (MemEn, MemWrite, ByteEn).
- Accepts one data access at a time over a ready/valid handshake. Applies a parameterised wait-state latency, then commits byte-lane-shifted writes or returns right-justified read data.
- Sits between the memory stage and on-chip data RAM. Sign/zero truncation stays downstream in the truncation logic.

Parameters:
- WORD_SIZE, 32, data width in bits; only 32 is supported (4 byte lanes).
- DEPTH_WORDS, 1024, RAM depth in words; must be a power of two.
- WAIT_STATES, 2, extra cycles between acceptance and response; range 0..15.

Ports:
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- MemEn  input  1  request valid
- MemWrite  input  1  1 = store, 0 = load; sampled with MemEn
- ByteEn  input  4  store lane pattern, unshifted: 0001 SB, 0011 SH, 1111 SW
- Size  input  2  load size: 00 byte, 01 half, 10 word (11 is illegal)
- Addr  input  32  byte address
- WriteData  input  32  store data, right-justified
- MemReady  output  1  responder can accept a request this cycle
- MemValid  output  1  one-cycle response strobe
- ReadData  output  32  load data, right-justified; valid only while MemValid=1
- MemFault  output  1  qualifies MemValid: access rejected

Behaviour:
- Reset (async, active-high):
  - state=IDLE, wait counter=0, MemReady=1, MemValid=0, MemFault=0, ReadData=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP. MemReady=1 only in IDLE.
- Acceptance: MemEn && MemReady on a rising edge.
  - Latch MemWrite, ByteEn, Size, Addr, WriteData.
  - Inputs are don't-care at all other times.
  - Go to WAIT with counter=WAIT_STATES-1, or straight to RESP when WAIT_STATES=0.
- WAIT: decrement the counter each cycle; go to RESP when the counter is 0.
- RESP:
  - Lasts exactly one cycle with MemValid=1, then returns to IDLE.
  - Latency: accept at edge N gives MemValid high in cycle N+WAIT_STATES+1.
  - Back-to-back throughput: one access per WAIT_STATES+2 cycles.
- Word index = Addr[clog2(DEPTH_WORDS)+1:2]; off = Addr[1:0].
- Fault conditions (evaluated on the latched request):
  - Addr bits above the index are nonzero (out of range).
  - Store: ByteEn not in {0001, 0011, 1111}; or ByteEn=0011 with off[0]=1; or ByteEn=1111 with off!=0.
  - Load: Size=11; or Size=01 with off[0]=1; or Size=10 with off!=0.
- On fault: no RAM change, MemFault=1 with MemValid, ReadData=0.
- Store commit:
  - Lane mask = ByteEn << off; data = WriteData << (8*off).
  - Only the masked lanes are written, on the edge entering RESP.
  - ReadData=0 during a store response.
- Load:
  - RAM word read on the edge entering RESP.
  - ReadData = word >> (8*off), upper bits zero-filled. Truncation to Size is not done here.
- A load immediately after a store to the same word returns the updated data, since the commit precedes the next acceptance.
- Reset mid-operation (WAIT or RESP) abandons the request:
  - A store not yet committed is discarded.
  - No MemValid is produced for it.
- MemEn held high while MemReady=0 is ignored, not queued.

Optional Feature:
- Macro: DATA_MEM_ACCESS_COUNT_EN.
- Defined:
  - Adds output ports LoadCount[31:0] and StoreCount[31:0].
  - Each increments in the RESP cycle of a non-faulting load or store respectively.
  - Both reset asynchronously to 0 and wrap at 2^32.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Default parameters, reset released, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each MemValid exactly 3 cycles after its accept; load ReadData=0xDEADBEEF, MemFault=0.
- After the SW above, SB addr 0x12 data 0x000000AA, then LW 0x10 -> ReadData=0xDEAABEEF. Follow with Size=00 load at 0x13 -> ReadData=0x000000DE.
- SH at 0x11 -> MemFault=1 with MemValid, word unchanged. LW at 0x1002 -> fault. Store with ByteEn=0101 -> fault.
- WAIT_STATES=0, four back-to-back loads with MemEn held high -> MemReady toggles 1,0 and MemValid pulses every 2 cycles. Requests during MemReady=0 are not accepted.
- Assert reset during WAIT of SW 0x20 data 0x12345678 -> no MemValid, all outputs at reset values immediately. A later LW 0x20 returns the prior contents.
- DATA_MEM_ACCESS_COUNT_EN defined: 3 good stores, 2 good loads, 1 faulting load -> StoreCount=3, LoadCount=2. After reset both are 0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// =============================================================================
// data_mem_responder_if : load/store request and response bundle between the
//                         memory stage and the data RAM responder.
// Revision: 1.0
// =============================================================================
interface data_mem_responder_if;
  logic        MemEn;
  logic        MemWrite;
  logic [3:0]  ByteEn;
  logic [1:0]  Size;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemReady;
  logic        MemValid;
  logic [31:0] ReadData;
  logic        MemFault;

  modport master (
    output MemEn, MemWrite, ByteEn, Size, Addr, WriteData,
    input  MemReady, MemValid, ReadData, MemFault
  );

  modport slave (
    input  MemEn, MemWrite, ByteEn, Size, Addr, WriteData,
    output MemReady, MemValid, ReadData, MemFault
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// =============================================================================
// data_mem_responder : single-outstanding data RAM responder with wait states,
//                      lane-shifted stores and right-justified loads.
//                      Optional access counters: DATA_MEM_ACCESS_COUNT_EN.
// Revision: 1.0
// =============================================================================
module data_mem_responder #(
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
`ifdef DATA_MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]         LoadCount,
  output logic [31:0]         StoreCount
`endif
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wr_q;
  logic [3:0]           be_q;
  logic [1:0]           size_q;
  logic [31:0]          addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 fault_q;

  logic [WORD_SIZE-1:0] mem [DEPTH_WORDS];
  logic [WORD_SIZE-1:0] ram_q;

  logic                 cur_wr;
  logic [3:0]           cur_be;
  logic [1:0]           cur_size;
  logic [31:0]          cur_addr;
  logic [WORD_SIZE-1:0] cur_wdata;
  logic [1:0]           off;
  logic [IDX_W-1:0]     idx;
  logic                 out_of_range;
  logic                 req_fault;
  logic [3:0]           lane_mask;
  logic [WORD_SIZE-1:0] wdata_sh;
  logic                 accept;
  logic                 enter_resp;
  logic                 commit_ok;

  // With zero wait states the RAM is touched on the accept edge itself, so
  // the live bus stands in for the not-yet-latched request while IDLE.
  assign cur_wr    = (state_q == S_IDLE) ? bus.MemWrite  : wr_q;
  assign cur_be    = (state_q == S_IDLE) ? bus.ByteEn    : be_q;
  assign cur_size  = (state_q == S_IDLE) ? bus.Size      : size_q;
  assign cur_addr  = (state_q == S_IDLE) ? bus.Addr      : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? bus.WriteData : wdata_q;

  assign off          = cur_addr[1:0];
  assign idx          = cur_addr[IDX_W+1:2];
  assign out_of_range = |cur_addr[31:IDX_W+2];
  assign lane_mask    = cur_be << off;
  assign wdata_sh     = cur_wdata << {off, 3'b000};

  always_comb begin
    req_fault = out_of_range;
    if (cur_wr) begin
      case (cur_be)
        4'b0001: req_fault = out_of_range;
        4'b0011: req_fault = out_of_range | off[0];
        4'b1111: req_fault = out_of_range | (off != 2'd0);
        default: req_fault = 1'b1;
      endcase
    end else begin
      case (cur_size)
        2'b00:   req_fault = out_of_range;
        2'b01:   req_fault = out_of_range | off[0];
        2'b10:   req_fault = out_of_range | (off != 2'd0);
        default: req_fault = 1'b1;
      endcase
    end
  end

  assign accept = (state_q == S_IDLE) && bus.MemEn;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.MemEn) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign commit_ok  = enter_resp && !req_fault && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.MemWrite;
        be_q    <= bus.ByteEn;
        size_q  <= bus.Size;
        addr_q  <= bus.Addr;
        wdata_q <= bus.WriteData;
      end
      if (enter_resp) fault_q <= req_fault;
    end
  end

  // RAM is not reset; a read captures the pre-write word, which only loads use.
  always_ff @(posedge clk) begin
    if (commit_ok) begin
      if (cur_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_mask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
      ram_q <= mem[idx];
    end
  end

  assign bus.MemReady = (state_q == S_IDLE);
  assign bus.MemValid = (state_q == S_RESP);
  assign bus.MemFault = (state_q == S_RESP) && fault_q;
  assign bus.ReadData = ((state_q == S_RESP) && !fault_q && !wr_q)
                        ? 32'(ram_q >> {addr_q[1:0], 3'b000}) : 32'd0;

`ifdef DATA_MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LoadCount  <= 32'd0;
      StoreCount <= 32'd0;
    end else if ((state_q == S_RESP) && !fault_q) begin
      if (wr_q) StoreCount <= StoreCount + 32'd1;
      else      LoadCount  <= LoadCount + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// =============================================================================
// tb_data_mem_responder : scoreboard bench with a byte-array reference model.
// Revision: 1.0
// =============================================================================
module tb_data_mem_responder;

  localparam int W    = 2;
  localparam int MLIM = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [31:0] lc, sc, lc0, sc0;
`endif

  data_mem_responder #(.WAIT_STATES(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DATA_MEM_ACCESS_COUNT_EN
    , .LoadCount(lc), .StoreCount(sc)
`endif
  );

  data_mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
`ifdef DATA_MEM_ACCESS_COUNT_EN
    , .LoadCount(lc0), .StoreCount(sc0)
`endif
  );

  typedef struct {
    logic        wr;
    logic [3:0]  be;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    time         t;
  } req_t;

  req_t        q[$];
  logic [7:0]  mem_m [MLIM];
  logic [31:0] pre [64];
  int          total  = 0;
  int          bad    = 0;
  int          exp_ld = 0;
  int          exp_st = 0;
  logic [31:0] last_rd  = 32'd0;
  logic        last_flt = 1'b0;
  req_t        mr;
  logic        mf;
  logic [31:0] md;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-addressed reference: an access of n bytes must be n-aligned and in range.
  function automatic void model(input req_t r, output logic flt, output logic [31:0] rd);
    int n, off, a;
    off = int'(r.addr[1:0]);
    flt = (r.addr >= 32'd4096);
    rd  = 32'd0;
    n   = 1;
    if (r.wr) begin
      if      (r.be == 4'b0001) n = 1;
      else if (r.be == 4'b0011) n = 2;
      else if (r.be == 4'b1111) n = 4;
      else                      flt = 1'b1;
    end else begin
      if (r.sz == 2'b11) flt = 1'b1;
      else               n = 1 << r.sz;
    end
    if (off % n != 0) flt = 1'b1;
    if (!flt) begin
      a = int'(r.addr[7:0]);
      if (r.wr) for (int i = 0; i < n; i++) mem_m[a + i] = r.wd[8*i +: 8];
      else      for (int i = 0; i < 4 - off; i++) rd[8*i +: 8] = mem_m[a + i];
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("ready", 32'(bus.MemReady), 32'(q.size() == 0));
      if (bus.MemValid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'(bus.MemValid), 32'd0);
        end else begin
          mr = q.pop_front();
          model(mr, mf, md);
          check("fault", 32'(bus.MemFault), 32'(mf));
          check("rdata", bus.ReadData, md);
          check("latency", 32'($time - mr.t), 32'(W*10 + 5));
          last_rd  = bus.ReadData;
          last_flt = bus.MemFault;
          if (!mf) begin
            if (mr.wr) exp_st++;
            else       exp_ld++;
          end
        end
      end else begin
        check("fault_no_valid", 32'(bus.MemFault), 32'd0);
      end
    end
  end

  task automatic issue(input logic wr, input logic [3:0] be, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    int g = 0;
    while (bus.MemReady !== 1'b1) begin
      @(negedge clk);
      g++;
      if (g > 40) begin
        check("ready_timeout", 32'(bus.MemReady), 32'd1);
        return;
      end
    end
    bus.MemEn     = 1'b1;
    bus.MemWrite  = wr;
    bus.ByteEn    = be;
    bus.Size      = sz;
    bus.Addr      = a;
    bus.WriteData = wd;
    @(posedge clk);
    q.push_back('{wr, be, sz, a, wd, $time});
    #1;
    bus.MemEn     = 1'b0;
    bus.MemWrite  = 1'($urandom);
    bus.ByteEn    = 4'($urandom);
    bus.Size      = 2'($urandom);
    bus.Addr      = $urandom;
    bus.WriteData = $urandom;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(bus.MemReady), 32'd1);
    check({tag, "_valid"},  32'(bus.MemValid), 32'd0);
    check({tag, "_fault"},  32'(bus.MemFault), 32'd0);
    check({tag, "_rdata"},  bus.ReadData,      32'd0);
    check({tag, "_ready0"}, 32'(bus0.MemReady), 32'd1);
    check({tag, "_valid0"}, 32'(bus0.MemValid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nval;
    bus.MemEn = 1'b0;  bus.MemWrite = 1'b0;  bus.ByteEn = 4'd0;  bus.Size = 2'd0;
    bus.Addr = 32'd0;  bus.WriteData = 32'd0;
    bus0.MemEn = 1'b0; bus0.MemWrite = 1'b0; bus0.ByteEn = 4'd0; bus0.Size = 2'd0;
    bus0.Addr = 32'd0; bus0.WriteData = 32'd0;

    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) begin
      pre[i] = $urandom;
      issue(1'b1, 4'hF, 2'b10, 32'(4*i), pre[i]);
    end
    wait_idle();

    issue(1'b1, 4'hF, 2'b10, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 4'h0, 2'b10, 32'h10, 32'h0);
    wait_idle();
    check("lw_10", last_rd, 32'hDEADBEEF);
    check("lw_10_fault", 32'(last_flt), 32'd0);

    issue(1'b1, 4'b0001, 2'b00, 32'h12, 32'h000000AA);
    issue(1'b0, 4'h0, 2'b10, 32'h10, 32'h0);
    wait_idle();
    check("lw_after_sb", last_rd, 32'hDEAABEEF);

    issue(1'b0, 4'h0, 2'b00, 32'h13, 32'h0);
    wait_idle();
    check("lb_13", last_rd, 32'h000000DE);

    issue(1'b1, 4'b0011, 2'b01, 32'h11, 32'h00005555);
    wait_idle();
    check("sh_11_fault", 32'(last_flt), 32'd1);
    issue(1'b0, 4'h0, 2'b10, 32'h10, 32'h0);
    wait_idle();
    check("word_unchanged", last_rd, 32'hDEAABEEF);

    issue(1'b0, 4'h0, 2'b10, 32'h1002, 32'h0);
    wait_idle();
    check("lw_1002_fault", 32'(last_flt), 32'd1);
    issue(1'b1, 4'b0101, 2'b00, 32'h10, 32'hFFFFFFFF);
    wait_idle();
    check("be_0101_fault", 32'(last_flt), 32'd1);

    // Reset lands while the store to 0x20 is still waiting.
    issue(1'b1, 4'hF, 2'b10, 32'h20, 32'h12345678);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid");
    q.delete();
    exp_ld = 0;
    exp_st = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

`ifdef DATA_MEM_ACCESS_COUNT_EN
    check("lc_reset", lc, 32'd0);
    check("sc_reset", sc, 32'd0);
    issue(1'b1, 4'hF, 2'b10, 32'h40, $urandom);
    issue(1'b1, 4'hF, 2'b10, 32'h44, $urandom);
    issue(1'b1, 4'b0001, 2'b00, 32'h49, $urandom);
    issue(1'b0, 4'h0, 2'b10, 32'h40, 32'h0);
    issue(1'b0, 4'h0, 2'b01, 32'h46, 32'h0);
    issue(1'b0, 4'h0, 2'b10, 32'h1000, 32'h0);
    wait_idle();
    check("sc_three", sc, 32'd3);
    check("lc_two", lc, 32'd2);
`endif

    issue(1'b0, 4'h0, 2'b10, 32'h20, 32'h0);
    wait_idle();
    check("lw_20_after_abort", last_rd, pre[8]);

    // Zero-wait-state instance: store, then loads with MemEn held high.
    @(negedge clk);
    bus0.MemEn = 1'b1; bus0.MemWrite = 1'b1; bus0.ByteEn = 4'hF; bus0.Size = 2'b10;
    bus0.Addr = 32'h0; bus0.WriteData = 32'hCAFEF00D;
    @(negedge clk);
    check("w0_store_valid", 32'(bus0.MemValid), 32'd1);
    check("w0_store_fault", 32'(bus0.MemFault), 32'd0);
    bus0.MemWrite = 1'b0;
    nval = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("w0_ready", 32'(bus0.MemReady), 32'(k % 2 == 0));
      check("w0_valid", 32'(bus0.MemValid), 32'(k % 2 == 1));
      if (bus0.MemValid) begin
        nval++;
        check("w0_rdata", bus0.ReadData, 32'hCAFEF00D);
      end
    end
    bus0.MemEn = 1'b0;
    check("w0_accepts", 32'(nval), 32'd4);

    for (int k = 0; k < 250; k++) begin
      logic [31:0] a;
      logic [3:0]  be;
      a = ($urandom_range(0, 9) == 0) ? (32'h1000 | $urandom) : 32'($urandom_range(0, MLIM - 1));
      case ($urandom_range(0, 3))
        0:       be = 4'b0001;
        1:       be = 4'b0011;
        2:       be = 4'b1111;
        default: be = 4'($urandom);
      endcase
      issue(1'($urandom), be, 2'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

`ifdef DATA_MEM_ACCESS_COUNT_EN
    check("lc_final", lc, 32'(exp_ld));
    check("sc_final", sc, 32'(exp_st));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
